// File: rtl/bullet_collider.sv
// Bullet table scanner: walks the compacted bullet list once per calc window,
// tests each valid entry against the target box and clears hit or off-screen bullets.
module bullet_collider #(
  parameter int ENTRIES  = 64,
  parameter int ADDR_W   = 6,
  parameter int SIZE     = 32,
  parameter int TARGET_W = 64,
  parameter int TARGET_H = 32,
  parameter int SCREEN_W = 1280
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              calc,
  input  logic [11:0]       target_x,
  input  logic [10:0]       target_y,
  input  logic              target_alive,
  output logic [ADDR_W-1:0] mem_rdaddress,
  input  logic [23:0]       mem_q,
  output logic [ADDR_W-1:0] mem_wraddress,
  output logic [23:0]       mem_data,
  output logic              mem_wren,
  output logic              busy,
  output logic              done,
  output logic              hit,
  output logic [7:0]        hit_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    CHECK  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ENTRIES - 1);

  state_t            state_r, state_s;
  logic              calc_d_r;
  logic [ADDR_W-1:0] rd_addr_r, rd_addr_s;
  logic [ADDR_W-1:0] wr_addr_r, wr_addr_s;
  logic              wren_r, wren_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              hit_r, hit_s;
  logic [7:0]        count_r, count_s;

  logic              start_s;
  logic [12:0]       bx_s;
  logic [11:0]       by_s;
  logic              coll_s;
  logic              off_s;

  assign start_s = calc & ~calc_d_r;
  assign bx_s    = {1'b0, mem_q[12:1]};
  assign by_s    = {1'b0, mem_q[23:13]};

  // Box overlap uses one-bit-wider sums so edges near the top of the range never wrap.
  assign coll_s = target_alive
               && ((bx_s + 13'(SIZE)) > {1'b0, target_x})
               && (bx_s < ({1'b0, target_x} + 13'(TARGET_W)))
               && ((by_s + 12'(SIZE)) > {1'b0, target_y})
               && (by_s < ({1'b0, target_y} + 12'(TARGET_H)));
  assign off_s  = bx_s >= 13'(SCREEN_W);

  assign mem_rdaddress = rd_addr_r;
  assign mem_wraddress = wr_addr_r;
  assign mem_data      = 24'd0;
  assign mem_wren      = wren_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign hit           = hit_r;
  assign hit_count     = count_r;

  // Next-state and next-output decode; a low calc during a scan aborts it.
  always_comb begin
    state_s   = state_r;
    rd_addr_s = rd_addr_r;
    wr_addr_s = wr_addr_r;
    wren_s    = 1'b0;
    busy_s    = busy_r;
    done_s    = 1'b0;
    hit_s     = 1'b0;
    count_s   = count_r;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          rd_addr_s = '0;
          count_s   = 8'd0;
          busy_s    = 1'b1;
          state_s   = ISSUE;
        end else begin
          busy_s = 1'b0;
        end
      end
      ISSUE: begin
        if (!calc) begin
          state_s = IDLE;
          busy_s  = 1'b0;
        end else begin
          state_s = CHECK;
        end
      end
      CHECK: begin
        if (!calc) begin
          state_s = IDLE;
          busy_s  = 1'b0;
        end else begin
          if (mem_q[0]) begin
            if (coll_s || off_s) begin
              wr_addr_s = rd_addr_r;
              wren_s    = 1'b1;
            end else begin
              wren_s = 1'b0;
            end
            hit_s = coll_s;
            if (coll_s && (count_r != 8'd255)) begin
              count_s = count_r + 8'd1;
            end else begin
              count_s = count_r;
            end
          end else begin
            hit_s = 1'b0;
          end
          // The table is compacted, so the first empty word ends the scan.
          if (!mem_q[0] || (rd_addr_r == LAST_ADDR)) begin
            state_s = FINISH;
            done_s  = 1'b1;
            busy_s  = 1'b0;
          end else begin
            rd_addr_s = rd_addr_r + ADDR_W'(1);
            state_s   = ISSUE;
          end
        end
      end
      FINISH: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      calc_d_r  <= 1'b0;
      rd_addr_r <= '0;
      wr_addr_r <= '0;
      wren_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      hit_r     <= 1'b0;
      count_r   <= 8'd0;
    end else begin
      state_r   <= state_s;
      calc_d_r  <= calc;
      rd_addr_r <= rd_addr_s;
      wr_addr_r <= wr_addr_s;
      wren_r    <= wren_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      hit_r     <= hit_s;
      count_r   <= count_s;
    end
  end

endmodule

// File: tb/tb_bullet_collider.sv
// Directed bench for bullet_collider: a RAM model, a box-overlap reference model
// computing per-cycle expectations, and a negedge compare process.
module tb_bullet_collider;

  localparam int N    = 64;
  localparam int MAXC = 140;

  logic        clock = 1'b0;
  logic        reset;
  logic        calc;
  logic [11:0] tx;
  logic [10:0] ty;
  logic        alive;
  logic [5:0]  mem_rdaddress;
  logic [23:0] mem_q;
  logic [5:0]  mem_wraddress;
  logic [23:0] mem_data;
  logic        mem_wren;
  logic        busy;
  logic        done;
  logic        hit;
  logic [7:0]  hit_count;

  bullet_collider dut (
    .clock(clock), .reset(reset), .calc(calc),
    .target_x(tx), .target_y(ty), .target_alive(alive),
    .mem_rdaddress(mem_rdaddress), .mem_q(mem_q),
    .mem_wraddress(mem_wraddress), .mem_data(mem_data), .mem_wren(mem_wren),
    .busy(busy), .done(done), .hit(hit), .hit_count(hit_count)
  );

  always #5 clock = ~clock;

  logic [23:0] ram      [N];
  logic [23:0] init_ram [N];
  logic [23:0] exp_ram  [N];
  logic        load_req;

  // Synchronous RAM: one-cycle read latency, write port driven by the DUT.
  always @(posedge clock) begin
    if (load_req) begin
      for (int i = 0; i < N; i++) ram[i] <= init_ram[i];
    end else begin
      mem_q <= ram[mem_rdaddress];
      if (mem_wren) ram[mem_wraddress] <= mem_data;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  int e_busy [MAXC], e_done [MAXC], e_hit [MAXC], e_wren [MAXC], e_wraddr [MAXC], e_cnt [MAXC];
  int busy_end;
  int cyc;
  logic chk_en;
  int seen_done_cyc, seen_hits, seen_writes;

  // Per-cycle comparison of the DUT against the model during a scan window.
  always @(negedge clock) begin
    if (!chk_en) begin
      seen_done_cyc = 0;
      seen_hits     = 0;
      seen_writes   = 0;
    end else if (cyc > 0) begin
      check($sformatf("busy@%0d", cyc), busy, e_busy[cyc]);
      check($sformatf("done@%0d", cyc), done, e_done[cyc]);
      check($sformatf("hit@%0d", cyc), hit, e_hit[cyc]);
      check($sformatf("wren@%0d", cyc), mem_wren, e_wren[cyc]);
      check($sformatf("hit_count@%0d", cyc), hit_count, e_cnt[cyc]);
      if (e_wren[cyc] != 0) begin
        check($sformatf("wraddr@%0d", cyc), mem_wraddress, e_wraddr[cyc]);
        check($sformatf("wdata@%0d", cyc), mem_data, 0);
      end
      if (cyc <= busy_end) check($sformatf("rdaddr@%0d", cyc), mem_rdaddress, (cyc - 1) / 2);
      if (done && seen_done_cyc == 0) seen_done_cyc = cyc;
      if (hit) seen_hits++;
      if (mem_wren) seen_writes++;
    end
  end

  task automatic load_ram();
    @(negedge clock); load_req = 1'b1;
    @(negedge clock); load_req = 1'b0;
  endtask

  task automatic clear_init();
    for (int i = 0; i < N; i++) init_ram[i] = 24'd0;
  endtask

  // Builds expectations from the bullet list and box rules, then runs one scan.
  // Cycle 1 is the first cycle after the edge that samples the calc rise.
  task automatic run_scan(input int abort_at);
    int n_chk, total, cnt, ec, bx, by;
    bit aborted, coll, off;
    n_chk = N;
    for (int i = 0; i < N; i++) begin
      if (init_ram[i][0] == 1'b0) begin
        n_chk = i + 1;
        break;
      end
    end
    aborted  = (abort_at != 0);
    busy_end = aborted ? abort_at : 2 * n_chk;
    total    = 2 * n_chk + 4;
    for (int c = 0; c < MAXC; c++) begin
      e_busy[c] = (c >= 1 && c <= busy_end) ? 1 : 0;
      e_done[c] = (!aborted && c == 2 * n_chk + 1) ? 1 : 0;
      e_hit[c] = 0; e_wren[c] = 0; e_wraddr[c] = 0; e_cnt[c] = 0;
    end
    for (int i = 0; i < N; i++) exp_ram[i] = init_ram[i];
    for (int i = 0; i < n_chk; i++) begin
      if (init_ram[i][0] && !(aborted && 2 * i + 2 >= abort_at)) begin
        bx   = int'(init_ram[i][12:1]);
        by   = int'(init_ram[i][23:13]);
        coll = alive && (bx + 32 > int'(tx)) && (bx < int'(tx) + 64)
                     && (by + 32 > int'(ty)) && (by < int'(ty) + 32);
        off  = bx >= 1280;
        ec   = 2 * i + 3;
        e_wren[ec]   = (coll || off) ? 1 : 0;
        e_wraddr[ec] = i;
        e_hit[ec]    = coll ? 1 : 0;
        if (coll || off) exp_ram[i] = 24'd0;
      end
    end
    cnt = 0;
    for (int c = 1; c < MAXC; c++) begin
      if (e_hit[c] != 0 && cnt < 255) cnt++;
      e_cnt[c] = cnt;
    end
    cyc = 0;
    chk_en = 1'b1;
    @(negedge clock); calc = 1'b1;
    for (int c = 1; c <= total; c++) begin
      @(posedge clock); #1;
      cyc = c;
      if (aborted && c == abort_at) calc = 1'b0;
      if (!aborted && c == 2 * n_chk + 2) calc = 1'b0;
    end
    @(negedge clock); #1;
    chk_en = 1'b0;
    cyc = 0;
    for (int i = 0; i < N; i++) check($sformatf("ram[%0d]", i), ram[i], exp_ram[i]);
  endtask

  initial begin
    reset = 1'b0; calc = 1'b0; tx = 12'd210; ty = 11'd90; alive = 1'b1;
    load_req = 1'b0; chk_en = 1'b0; cyc = 0; busy_end = 0;
    clear_init();
    repeat (3) @(negedge clock);
    check("reset_busy", busy, 0);
    check("reset_wren", mem_wren, 0);
    check("reset_count", hit_count, 0);
    check("reset_rdaddr", mem_rdaddress, 0);
    reset = 1'b1;

    // Single colliding bullet.
    init_ram[0] = {11'd100, 12'd200, 1'b1};
    load_ram();
    run_scan(0);
    check("hit1_done_cycle", seen_done_cyc, 5);
    check("hit1_hits", seen_hits, 1);
    check("hit1_count", hit_count, 1);

    // Same bullet, target dead.
    alive = 1'b0;
    load_ram();
    run_scan(0);
    check("dead_done_cycle", seen_done_cyc, 5);
    check("dead_writes", seen_writes, 0);
    check("dead_count", hit_count, 0);
    alive = 1'b1;

    // Off-screen bullet without overlap.
    init_ram[0] = {11'd50, 12'd1285, 1'b1};
    load_ram();
    run_scan(0);
    check("off_writes", seen_writes, 1);
    check("off_hits", seen_hits, 0);
    check("off_count", hit_count, 0);

    // Right-edge boundary: x = tx+64 touches only, x = tx+63 overlaps.
    tx = 12'd300; ty = 11'd200;
    init_ram[0] = {11'd200, 12'd364, 1'b1};
    init_ram[1] = {11'd200, 12'd363, 1'b1};
    load_ram();
    run_scan(0);
    check("edge_hits", seen_hits, 1);
    check("edge_done_cycle", seen_done_cyc, 7);
    check("edge_ram0_kept", ram[0], 24'h190000 | (24'd364 << 1) | 24'd1);

    // Full table, every entry colliding.
    tx = 12'd210; ty = 11'd90;
    for (int i = 0; i < N; i++) init_ram[i] = {11'd100, 12'd200, 1'b1};
    load_ram();
    run_scan(0);
    check("full_done_cycle", seen_done_cyc, 129);
    check("full_hits", seen_hits, 64);
    check("full_writes", seen_writes, 64);
    check("full_count", hit_count, 64);

    // Full table, calc dropped at cycle 20.
    load_ram();
    run_scan(20);
    check("abort_done", seen_done_cyc, 0);
    check("abort_count", hit_count, 9);
    check("abort_writes", seen_writes, 9);

    // Async reset in the middle of a scan.
    load_ram();
    @(negedge clock); calc = 1'b1;
    repeat (21) @(posedge clock);
    #2;
    check("pre_reset_rdaddr", mem_rdaddress, 10);
    check("pre_reset_busy", busy, 1);
    reset = 1'b0; calc = 1'b0;
    #1;
    check("mid_reset_busy", busy, 0);
    check("mid_reset_rdaddr", mem_rdaddress, 0);
    check("mid_reset_wraddr", mem_wraddress, 0);
    check("mid_reset_wren", mem_wren, 0);
    check("mid_reset_done", done, 0);
    check("mid_reset_hit", hit, 0);
    check("mid_reset_count", hit_count, 0);
    @(negedge clock); reset = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      check($sformatf("idle_wren@%0d", c), mem_wren, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
